// File: rtl/vga_timing_pkg.sv
// Timing constants and helpers shared by the VGA sync generator.
// Segment lengths default to 640x480@60; totals are 10-bit unsigned sums.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE_640 = 640;
  localparam int unsigned H_FRONT_640   = 16;
  localparam int unsigned H_SYNC_640    = 96;
  localparam int unsigned H_BACK_640    = 48;

  localparam int unsigned V_VISIBLE_480 = 480;
  localparam int unsigned V_FRONT_480   = 10;
  localparam int unsigned V_SYNC_480    = 2;
  localparam int unsigned V_BACK_480    = 33;

  function automatic coord_t to_coord(input int unsigned val);
    return coord_t'(val);
  endfunction

  // A total of exactly 1024 wraps to 0, so total-1 still lands on 1023.
  function automatic coord_t h_total(input int unsigned visible, input int unsigned front,
                                     input int unsigned sync, input int unsigned back);
    return to_coord(visible + front + sync + back);
  endfunction

  function automatic coord_t v_total(input int unsigned visible, input int unsigned front,
                                     input int unsigned sync, input int unsigned back);
    return to_coord(visible + front + sync + back);
  endfunction

  function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel clock divider: counts 0..CLK_DIV-1 and emits a registered strobe per pixel.
// o_adv is the combinational advance used by the counters in the same cycle.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_adv,
  output logic o_pixel_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_pixel_tick;
  logic             w_adv;

  // With CLK_DIV = 1 the divider sits at 0 and advances every clock.
  assign w_adv = (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div        <= '0;
      r_pixel_tick <= 1'b0;
    end else begin
      r_div        <= w_adv ? '0 : r_div + 1'b1;
      r_pixel_tick <= w_adv;
    end
  end

  assign o_adv        = w_adv;
  assign o_pixel_tick = r_pixel_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v counters, sync decode and visible-area enable.
// Define VGA_FRAME_PULSE_EN to add the frame_pulse output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = H_VISIBLE_640,
  parameter int unsigned H_FRONT   = H_FRONT_640,
  parameter int unsigned H_SYNC    = H_SYNC_640,
  parameter int unsigned H_BACK    = H_BACK_640,
  parameter int unsigned V_VISIBLE = V_VISIBLE_480,
  parameter int unsigned V_FRONT   = V_FRONT_480,
  parameter int unsigned V_SYNC    = V_SYNC_480,
  parameter int unsigned V_BACK    = V_BACK_480
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               Hsync,
  output logic               Vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_tick
`ifdef VGA_FRAME_PULSE_EN
  ,
  output logic               frame_pulse
`endif
);

  localparam coord_t H_TOTAL  = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam coord_t V_TOTAL  = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam coord_t H_LAST   = H_TOTAL - coord_t'(1);
  localparam coord_t V_LAST   = V_TOTAL - coord_t'(1);
  localparam coord_t H_VIS    = to_coord(H_VISIBLE);
  localparam coord_t V_VIS    = to_coord(V_VISIBLE);
  localparam coord_t HS_START = to_coord(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = to_coord(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = to_coord(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = to_coord(V_VISIBLE + V_FRONT + V_SYNC);

  logic   w_adv;
  logic   w_h_wrap;
  logic   w_v_wrap;
  coord_t w_h_next;
  coord_t w_v_next;

  coord_t r_h;
  coord_t r_v;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_video_on;

  pix_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick_gen (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .o_adv       (w_adv),
    .o_pixel_tick(pixel_tick)
  );

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);

  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_adv) begin
      w_h_next = w_h_wrap ? '0 : r_h + 1'b1;
      if (w_h_wrap) begin
        w_v_next = w_v_wrap ? '0 : r_v + 1'b1;
      end
    end
  end

  // Sync and enable decode the next-state counters so they move with pixel_x/pixel_y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h        <= '0;
      r_v        <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
    end else begin
      r_h        <= w_h_next;
      r_v        <= w_v_next;
      r_hsync    <= !in_window(w_h_next, HS_START, HS_END);
      r_vsync    <= !in_window(w_v_next, VS_START, VS_END);
      r_video_on <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
    end
  end

`ifdef VGA_FRAME_PULSE_EN
  logic r_frame_pulse;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_pulse <= 1'b0;
    end else begin
      r_frame_pulse <= w_adv && w_h_wrap && w_v_wrap;
    end
  end

  assign frame_pulse = r_frame_pulse;
`endif

  assign Hsync    = r_hsync;
  assign Vsync    = r_vsync;
  assign video_on = r_video_on;
  assign pixel_x  = r_h;
  assign pixel_y  = r_v;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a CLK_DIV=1 short-frame instance,
// each checked every cycle against an elapsed-time raster model plus directed literals.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vo;
    logic       tick;
    logic       fp;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  logic       a_hs, a_vs, a_vo, a_tick;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_vo, b_tick;
  logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_PULSE_EN
  logic a_fp, b_fp;
`endif

  int    checks = 0;
  int    errors = 0;
  longint t_a = 0;
  longint t_b = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_a (
    .clk        (clk),
    .reset_n    (rst_a_n),
    .Hsync      (a_hs),
    .Vsync      (a_vs),
    .video_on   (a_vo),
    .pixel_x    (a_x),
    .pixel_y    (a_y),
    .pixel_tick (a_tick)
`ifdef VGA_FRAME_PULSE_EN
    ,
    .frame_pulse(a_fp)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV  (1),
    .V_VISIBLE(6),
    .V_FRONT  (2),
    .V_SYNC   (2),
    .V_BACK   (3)
  ) dut_b (
    .clk        (clk),
    .reset_n    (rst_b_n),
    .Hsync      (b_hs),
    .Vsync      (b_vs),
    .video_on   (b_vo),
    .pixel_x    (b_x),
    .pixel_y    (b_y),
    .pixel_tick (b_tick)
`ifdef VGA_FRAME_PULSE_EN
    ,
    .frame_pulse(b_fp)
`endif
  );

  // Elapsed clock edges since reset release drive the model.
  always @(posedge clk) if (rst_a_n) t_a = t_a + 1;
  always @(posedge clk) if (rst_b_n) t_b = t_b + 1;
  always @(negedge rst_a_n) t_a = 0;
  always @(negedge rst_b_n) t_b = 0;

  function automatic exp_t model(input longint t, input int cd, input int hv, input int hf,
                                 input int hsn, input int hb, input int vv, input int vf,
                                 input int vsn, input int vb);
    exp_t   e;
    longint p, ht, vt;
    int     h, v;
    ht     = hv + hf + hsn + hb;
    vt     = vv + vf + vsn + vb;
    p      = t / cd;
    h      = int'(p % ht);
    v      = int'((p / ht) % vt);
    e.x    = 10'(h);
    e.y    = 10'(v);
    e.hs   = !(h >= hv + hf && h < hv + hf + hsn);
    e.vs   = !(v >= vv + vf && v < vv + vf + vsn);
    e.vo   = (t > 0) && (h < hv) && (v < vv);
    e.tick = (t > 0) && (t % cd == 0);
    e.fp   = e.tick && (p % (ht * vt) == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t_a=%0d t_b=%0d)", name, act, exp, t_a, t_b);
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t ea, eb;
    ea = model(t_a, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    eb = model(t_b, 1, 640, 16, 96, 48, 6, 2, 2, 3);
    chk("a_hsync", a_hs, ea.hs);
    chk("a_vsync", a_vs, ea.vs);
    chk("a_video_on", a_vo, ea.vo);
    chk("a_pixel_tick", a_tick, ea.tick);
    chk("a_pixel_x", a_x, ea.x);
    chk("a_pixel_y", a_y, ea.y);
    chk("b_hsync", b_hs, eb.hs);
    chk("b_vsync", b_vs, eb.vs);
    chk("b_video_on", b_vo, eb.vo);
    chk("b_pixel_tick", b_tick, eb.tick);
    chk("b_pixel_x", b_x, eb.x);
    chk("b_pixel_y", b_y, eb.y);
`ifdef VGA_FRAME_PULSE_EN
    chk("a_frame_pulse", a_fp, ea.fp);
    chk("b_frame_pulse", b_fp, eb.fp);
`endif
  end

  // Called just after a release (posedge + 2).
  task automatic release_checks_a();
    @(negedge clk);
    chk("a_rel0_tick", a_tick, 0);
    chk("a_rel0_video_on", a_vo, 0);
    @(negedge clk);
    chk("a_rel1_tick", a_tick, 0);
    chk("a_rel1_video_on", a_vo, 1);
    chk("a_rel1_hsync", a_hs, 1);
    chk("a_rel1_vsync", a_vs, 1);
    chk("a_rel1_x", a_x, 0);
    @(negedge clk);
    chk("a_rel2_tick", a_tick, 1);
    chk("a_rel2_x", a_x, 1);
    @(negedge clk);
    chk("a_rel3_tick", a_tick, 0);
    chk("a_rel3_x", a_x, 1);
  endtask

  task automatic release_checks_b();
    @(negedge clk);
    chk("b_rel0_tick", b_tick, 0);
    @(negedge clk);
    chk("b_rel1_tick", b_tick, 1);
    chk("b_rel1_x", b_x, 1);
    chk("b_rel1_y", b_y, 0);
    @(negedge clk);
    chk("b_rel2_tick", b_tick, 1);
    chk("b_rel2_x", b_x, 2);
  endtask

  initial begin : stim
    int a_fall1, a_fall2, a_low, a_rise_x, a_fall_x, a_vo_fall_x;
    int b_hfall1, b_hfall2, b_vfall_y, b_vrise_y, b_vrise_x, b_vlow, b_vrise1, b_vrise2;
    int b_wrap_ok, b_tick_low, b_fp_cnt, b_fp_wrap;
    logic p_ahs, p_avo, p_bhs, p_bvs, a_low_done, b_vlow_done;
    logic [9:0] p_bx, p_by;
    bit found;

    a_fall1 = -1; a_fall2 = -1; a_low = 0; a_rise_x = -1; a_fall_x = -1; a_vo_fall_x = -1;
    b_hfall1 = -1; b_hfall2 = -1; b_vfall_y = -1; b_vrise_y = -1; b_vrise_x = -1;
    b_vlow = 0; b_vrise1 = -1; b_vrise2 = -1; b_wrap_ok = 0; b_tick_low = 0;
    b_fp_cnt = 0; b_fp_wrap = 0; a_low_done = 0; b_vlow_done = 0;

    repeat (3) @(posedge clk);
    #2;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      release_checks_a();
      release_checks_b();
    join

    p_ahs = a_hs; p_avo = a_vo; p_bhs = b_hs; p_bvs = b_vs; p_bx = b_x; p_by = b_y;
    for (int cyc = 0; cyc < 24000; cyc++) begin
      @(negedge clk);
      if (p_ahs && !a_hs) begin
        if (a_fall1 < 0) begin a_fall1 = cyc; a_fall_x = int'(a_x); end
        else if (a_fall2 < 0) a_fall2 = cyc;
      end
      if (!a_hs && a_fall1 >= 0 && !a_low_done) a_low++;
      if (!p_ahs && a_hs && a_fall1 >= 0 && !a_low_done) begin
        a_low_done = 1; a_rise_x = int'(a_x);
      end
      if (p_avo && !a_vo && a_vo_fall_x < 0) a_vo_fall_x = int'(a_x);
      if (p_bhs && !b_hs) begin
        if (b_hfall1 < 0) b_hfall1 = cyc;
        else if (b_hfall2 < 0) b_hfall2 = cyc;
      end
      if (p_bvs && !b_vs && b_vfall_y < 0) b_vfall_y = int'(b_y);
      if (!b_vs && b_vfall_y >= 0 && !b_vlow_done) b_vlow++;
      if (!p_bvs && b_vs) begin
        if (b_vrise1 < 0) begin
          b_vrise1 = cyc; b_vrise_y = int'(b_y); b_vrise_x = int'(b_x); b_vlow_done = 1;
        end else if (b_vrise2 < 0) b_vrise2 = cyc;
      end
      if (p_bx == 10'd799 && p_by == 10'd12 && b_x == 10'd0 && b_y == 10'd0) begin
        b_wrap_ok++;
`ifdef VGA_FRAME_PULSE_EN
        if (b_fp) b_fp_wrap++;
`endif
      end
`ifdef VGA_FRAME_PULSE_EN
      if (b_fp) b_fp_cnt++;
`endif
      if (!b_tick) b_tick_low++;
      p_ahs = a_hs; p_avo = a_vo; p_bhs = b_hs; p_bvs = b_vs; p_bx = b_x; p_by = b_y;
    end

    chk("a_hsync_fall_x", a_fall_x, 656);
    chk("a_hsync_low_clks", a_low, 192);
    chk("a_hsync_rise_x", a_rise_x, 752);
    chk("a_video_on_fall_x", a_vo_fall_x, 640);
    chk("a_line_clks", a_fall2 - a_fall1, 1600);
    chk("b_line_clks", b_hfall2 - b_hfall1, 800);
    chk("b_vsync_fall_y", b_vfall_y, 8);
    chk("b_vsync_low_clks", b_vlow, 1600);
    chk("b_vsync_rise_y", b_vrise_y, 10);
    chk("b_vsync_rise_x", b_vrise_x, 0);
    chk("b_frame_clks", b_vrise2 - b_vrise1, 10400);
    chk("b_wrap_count", b_wrap_ok, 2);
    chk("b_tick_low_clks", b_tick_low, 0);
`ifdef VGA_FRAME_PULSE_EN
    chk("b_frame_pulse_count", b_fp_cnt, 2);
    chk("b_frame_pulse_at_wrap", b_fp_wrap, 2);
`endif

    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (a_x == 10'd700) found = 1;
    end
    chk("a_wait_x700", found, 1);
    if (found) begin
      chk("a_mid_hsync_low", a_hs, 0);
      @(posedge clk);
      #2;
      rst_a_n = 1'b0;
      #1;
      chk("a_rst_hsync", a_hs, 1);
      chk("a_rst_x", a_x, 0);
      chk("a_rst_y", a_y, 0);
      chk("a_rst_video_on", a_vo, 0);
      chk("a_rst_tick", a_tick, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_a_n = 1'b1;
      release_checks_a();
    end

    found = 0;
    for (int i = 0; i < 11000 && !found; i++) begin
      @(negedge clk);
      if (b_x == 10'd700 && b_y == 10'd3) found = 1;
    end
    chk("b_wait_x700_y3", found, 1);
    if (found) begin
      chk("b_mid_hsync_low", b_hs, 0);
      @(posedge clk);
      #2;
      rst_b_n = 1'b0;
      #1;
      chk("b_rst_hsync", b_hs, 1);
      chk("b_rst_vsync", b_vs, 1);
      chk("b_rst_x", b_x, 0);
      chk("b_rst_y", b_y, 0);
      chk("b_rst_tick", b_tick, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_b_n = 1'b1;
      release_checks_b();
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
